// File: rtl/mio_pkg.sv
// Shared types and constants for the loadable MIO program memory.
package mio_pkg;
    localparam int MIO_W = 32;
    localparam int DEF_DEPTH_LOG2 = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_RUN,
        S_ERR
    } state_t;
endpackage

// File: rtl/mio_ram_loader_if.sv
// Host load stream, CPU read ports and loader status for the MIO RAM.
interface mio_ram_loader_if #(
    parameter int DEPTH_LOG2 = mio_pkg::DEF_DEPTH_LOG2
);
    import mio_pkg::*;

    logic                  load_req;
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [MIO_W-1:0]      a;
    logic [MIO_W-1:0]      inst;
    logic [MIO_W-1:0]      rom_a;
    logic [MIO_W-1:0]      d_f_rom;
    logic                  cpu_hold;
    logic                  load_done;
    logic                  load_err;
    logic [DEPTH_LOG2-1:0] load_addr;

    modport master (
        output load_req, rx_data, rx_valid, a, rom_a,
        input  rx_ready, inst, d_f_rom, cpu_hold,
        input  load_done, load_err, load_addr
    );

    modport slave (
        input  load_req, rx_data, rx_valid, a, rom_a,
        output rx_ready, inst, d_f_rom, cpu_hold,
        output load_done, load_err, load_addr
    );
endinterface

// File: rtl/mio_dpram.sv
// Word RAM: one synchronous write port, two asynchronous read ports.
module mio_dpram #(
    parameter int AW = 7,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr0,
    output logic [DW-1:0] o_rdata0,
    input  logic [AW-1:0] i_raddr1,
    output logic [DW-1:0] o_rdata1
);
    logic [DW-1:0] r_mem [2**AW];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata0 = r_mem[i_raddr0];
    assign o_rdata1 = r_mem[i_raddr1];
endmodule

// File: rtl/mio_ram_loader.sv
// Loads a checksummed big-endian byte image into program RAM while
// holding the CPU, then serves it on the fetch and data read ports.
module mio_ram_loader
    import mio_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter int WORDS      = 128
) (
    input logic            clk,
    input logic            clrn,
    mio_ram_loader_if.slave bus
);
    localparam logic [DEPTH_LOG2-1:0] LAST = DEPTH_LOG2'(WORDS - 1);

    state_t                r_state;
    logic [1:0]            r_lane;
    logic [23:0]           r_shift;
    logic [7:0]            r_sum;
    logic [DEPTH_LOG2-1:0] r_addr;
    logic                  r_rdy;
    logic                  r_hold;
    logic                  r_done;
    logic                  r_err;

    logic                  w_acc;
    logic                  w_we;
    logic                  w_last;
    logic [7:0]            w_sum;
    logic [DEPTH_LOG2-1:0] w_ra0;
    logic [DEPTH_LOG2-1:0] w_ra1;
    logic                  w_unused;

    // A restart request swallows any byte offered in the same cycle.
    assign w_acc  = bus.rx_valid & r_rdy & ~bus.load_req;
    assign w_we   = w_acc & (r_state == S_LOAD) & (r_lane == 2'd3);
    assign w_last = (r_addr == LAST);
    assign w_sum  = r_sum + bus.rx_data;
    assign w_ra0  = bus.a[DEPTH_LOG2+1:2];
    assign w_ra1  = bus.rom_a[DEPTH_LOG2+1:2];

    assign w_unused = ^{bus.a[MIO_W-1:DEPTH_LOG2+2], bus.a[1:0],
                        bus.rom_a[MIO_W-1:DEPTH_LOG2+2], bus.rom_a[1:0]};

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= S_IDLE;
            r_lane  <= '0;
            r_shift <= '0;
            r_sum   <= '0;
            r_addr  <= '0;
            r_rdy   <= 1'b0;
            r_hold  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else if (bus.load_req) begin
            r_state <= S_LOAD;
            r_lane  <= '0;
            r_sum   <= '0;
            r_addr  <= '0;
            r_rdy   <= 1'b1;
            r_hold  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            unique case (r_state)
                S_LOAD: begin
                    if (w_acc) begin
                        r_sum   <= w_sum;
                        r_lane  <= r_lane + 2'd1;
                        r_shift <= {r_shift[15:0], bus.rx_data};
                        if (r_lane == 2'd3) begin
                            r_addr <= w_last ? '0 : r_addr + 1'b1;
                            if (w_last) r_state <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (w_acc) begin
                        r_rdy <= 1'b0;
                        if (w_sum == 8'h00) begin
                            r_state <= S_RUN;
                            r_hold  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    mio_dpram #(
        .AW(DEPTH_LOG2),
        .DW(MIO_W)
    ) u_ram (
        .clk      (clk),
        .i_we     (w_we),
        .i_waddr  (r_addr),
        .i_wdata  ({r_shift, bus.rx_data}),
        .i_raddr0 (w_ra0),
        .o_rdata0 (bus.inst),
        .i_raddr1 (w_ra1),
        .o_rdata1 (bus.d_f_rom)
    );

    assign bus.rx_ready  = r_rdy;
    assign bus.cpu_hold  = r_hold;
    assign bus.load_done = r_done;
    assign bus.load_err  = r_err;
    assign bus.load_addr = r_addr;
endmodule

// File: tb/tb_mio_ram_loader.sv
// Bench for mio_ram_loader: byte-stream model plus directed checks.
module tb_mio_ram_loader;
    import mio_pkg::*;

    localparam int DL = 7;
    localparam int W  = 128;
    localparam int NB = 4 * W;

    typedef enum {M_IDLE, M_LOAD, M_CHECK, M_RUN, M_ERR} mmode_t;

    logic clk  = 1'b0;
    logic clrn = 1'b0;
    always #5 clk = ~clk;

    mio_ram_loader_if #(.DEPTH_LOG2(DL)) bus ();

    mio_ram_loader #(.DEPTH_LOG2(DL), .WORDS(W)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    logic [7:0] img [NB];

    function automatic void build(int salt);
        logic [31:0] wd;
        for (int w = 0; w < W; w++) begin
            wd = {8'(w + salt), 8'(w * 3), 8'(w ^ 'h5A), 8'(w + 7)};
            if (salt == 0 && w == 0)    wd = 32'h201D1000;
            if (salt == 0 && w == 'h40) wd = 32'h08000040;
            for (int k = 0; k < 4; k++) img[4*w+k] = wd[31-8*k -: 8];
        end
    endfunction

    function automatic logic [7:0] cksum();
        logic [7:0] s = 8'h00;
        for (int i = 0; i < NB; i++) s = s + img[i];
        return 8'h00 - s;
    endfunction

    // Reference: count accepted bytes, keep words and running sum.
    mmode_t      m_mode = M_IDLE;
    int          m_n    = 0;
    logic [7:0]  m_sum  = 8'h00;
    logic [31:0] m_word = 32'h0;
    logic [31:0] m_mem [W];
    bit          m_vld [W];

    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            m_mode = M_IDLE;
            m_n    = 0;
        end else if (bus.load_req) begin
            m_mode = M_LOAD;
            m_n    = 0;
            m_sum  = 8'h00;
        end else if (bus.rx_valid && m_mode == M_LOAD) begin
            m_sum  = m_sum + bus.rx_data;
            m_word = {m_word[23:0], bus.rx_data};
            m_n++;
            if (m_n % 4 == 0) begin
                m_mem[m_n/4-1] = m_word;
                m_vld[m_n/4-1] = 1'b1;
            end
            if (m_n == NB) m_mode = M_CHECK;
        end else if (bus.rx_valid && m_mode == M_CHECK) begin
            m_mode = (8'(m_sum + bus.rx_data) == 8'h00) ? M_RUN : M_ERR;
        end
    end

    bit cmp_en   = 1'b0;
    bit rnd_addr = 1'b0;

    always @(posedge clk) begin
        if (rnd_addr) begin
            #2;
            bus.a     = $urandom;
            bus.rom_a = $urandom;
        end
    end

    always @(negedge clk) begin
        if (cmp_en && clrn) begin
            chk("rx_ready", 32'(bus.rx_ready),
                32'(m_mode == M_LOAD || m_mode == M_CHECK));
            chk("cpu_hold", 32'(bus.cpu_hold), 32'(m_mode != M_RUN));
            chk("load_done", 32'(bus.load_done), 32'(m_mode == M_RUN));
            chk("load_err", 32'(bus.load_err), 32'(m_mode == M_ERR));
            chk("load_addr", 32'(bus.load_addr), 32'((m_n / 4) % W));
            if (m_vld[bus.a[8:2]])
                chk("inst", bus.inst, m_mem[bus.a[8:2]]);
            if (m_vld[bus.rom_a[8:2]])
                chk("d_f_rom", bus.d_f_rom, m_mem[bus.rom_a[8:2]]);
        end
    end

    task automatic idle(int n);
        repeat (n) begin
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic send(logic [7:0] b, int gmax);
        idle($urandom_range(gmax, 0));
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic pulse_req();
        bus.load_req = 1'b1;
        @(negedge clk);
        bus.load_req = 1'b0;
    endtask

    task automatic send_img(int gmax);
        for (int i = 0; i < NB; i++) send(img[i], gmax);
    endtask

    task automatic set_addr(logic [31:0] ia, logic [31:0] da);
        @(posedge clk);
        #2;
        bus.a     = ia;
        bus.rom_a = da;
        #1;
    endtask

    logic [7:0] ck;

    initial begin
        bus.load_req = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.a        = '0;
        bus.rom_a    = '0;
        repeat (3) @(negedge clk);
        chk("rst_hold", 32'(bus.cpu_hold), 32'd1);
        chk("rst_ready", 32'(bus.rx_ready), 32'd0);
        chk("rst_done", 32'(bus.load_done), 32'd0);
        chk("rst_err", 32'(bus.load_err), 32'd0);
        chk("rst_addr", 32'(bus.load_addr), 32'd0);
        clrn = 1'b1;
        cmp_en = 1'b1;
        rnd_addr = 1'b1;
        idle(100);

        build(0);
        ck = cksum();
        pulse_req();
        send_img(0);
        chk("pre_ck_hold", 32'(bus.cpu_hold), 32'd1);
        bus.rx_valid = 1'b1;
        bus.rx_data  = ck;
        @(posedge clk);
        #1;
        chk("ck_edge_hold", 32'(bus.cpu_hold), 32'd0);
        chk("ck_edge_done", 32'(bus.load_done), 32'd1);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        rnd_addr = 1'b0;
        set_addr(32'h0000_0000, 32'h0000_0100);
        chk("inst_w0", bus.inst, 32'h201D1000);
        chk("drom_w40", bus.d_f_rom, 32'h08000040);
        set_addr(32'hABCD_E003, 32'h1234_5102);
        chk("inst_hi_bits", bus.inst, 32'h201D1000);
        chk("drom_hi_bits", bus.d_f_rom, 32'h08000040);
        set_addr(32'h0000_0104, 32'hF000_0105);
        chk("inst_w41", bus.inst, 32'h41C31B48);
        chk("same_word", bus.d_f_rom, bus.inst);
        @(negedge clk);
        rnd_addr = 1'b1;

        pulse_req();
        send_img(0);
        send(ck + 8'h01, 0);
        chk("bad_err", 32'(bus.load_err), 32'd1);
        chk("bad_done", 32'(bus.load_done), 32'd0);
        chk("bad_hold", 32'(bus.cpu_hold), 32'd1);
        idle(5);
        pulse_req();
        send_img(0);
        send(ck, 0);
        chk("reload_done", 32'(bus.load_done), 32'd1);

        build(5);
        ck = cksum();
        pulse_req();
        send_img(5);
        send(ck, 3);
        chk("gap_done", 32'(bus.load_done), 32'd1);
        rnd_addr = 1'b0;
        for (int i = 0; i < W; i++) begin
            set_addr(32'(i * 4), 32'(i * 4));
            chk("gap_word", bus.inst,
                {img[4*i], img[4*i+1], img[4*i+2], img[4*i+3]});
        end
        @(negedge clk);
        rnd_addr = 1'b1;

        build(0);
        ck = cksum();
        pulse_req();
        for (int i = 0; i < 37; i++) send(8'($urandom), 1);
        bus.load_req = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hFF;
        @(negedge clk);
        bus.load_req = 1'b0;
        bus.rx_valid = 1'b0;
        chk("restart_addr", 32'(bus.load_addr), 32'd0);
        send_img(2);
        send(ck, 0);
        chk("restart_done", 32'(bus.load_done), 32'd1);

        idle(3);
        bus.load_req = 1'b1;
        @(posedge clk);
        #1;
        chk("run_req_hold", 32'(bus.cpu_hold), 32'd1);
        chk("run_req_ready", 32'(bus.rx_ready), 32'd1);
        chk("run_req_done", 32'(bus.load_done), 32'd0);
        @(negedge clk);
        bus.load_req = 1'b0;

        for (int i = 0; i < 10; i++) send(8'(i + 'h90), 0);
        #2;
        clrn = 1'b0;
        #1;
        chk("arst_hold", 32'(bus.cpu_hold), 32'd1);
        chk("arst_ready", 32'(bus.rx_ready), 32'd0);
        chk("arst_addr", 32'(bus.load_addr), 32'd0);
        @(negedge clk);
        clrn = 1'b1;
        idle(10);

        cmp_en = 1'b0;
        rnd_addr = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mio_ram_loader.md
Name: mio_ram_loader

Overview:
- Loadable replacement for the fixed 128-word instruction/data ROM on the MIO bus.
- A host byte stream (UART receiver or debug port) writes a program image into a 128x32 RAM while the CPU is held.
- The same image is then served on two combinational read ports: the instruction fetch port and the data read port.
- This block is the writer end of the program memory; the CPU remains the reader.

Parameters:
- DEPTH_LOG2, 7, log2 of word count; the RAM holds 2**DEPTH_LOG2 words, indexed by address bits [DEPTH_LOG2+1:2].
- WORDS, 128, number of words in one load image; must satisfy 1 <= WORDS <= 2**DEPTH_LOG2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- clrn  in  1  asynchronous active-low reset.
- load_req  in  1  single-cycle pulse that starts or restarts a load.
- rx_data  in  8  image byte from the host.
- rx_valid  in  1  rx_data is valid this cycle.
- rx_ready  out  1  block accepts a byte this cycle.
- a  in  32  instruction fetch byte address.
- inst  out  32  word at a[DEPTH_LOG2+1:2]; combinational.
- rom_a  in  32  data read byte address.
- d_f_rom  out  32  word at rom_a[DEPTH_LOG2+1:2]; combinational.
- cpu_hold  out  1  CPU must stall or stay in reset while high.
- load_done  out  1  the last load passed its checksum.
- load_err  out  1  the last load failed its checksum.
- load_addr  out  DEPTH_LOG2  index of the next word to be written.

Behaviour:
- Reset values: rx_ready=0, cpu_hold=1, load_done=0, load_err=0, load_addr=0, FSM in IDLE.
- RAM contents are not reset and are undefined until the first load completes.
- A byte is accepted when rx_valid & rx_ready are both high on a rising edge. rx_data is ignored otherwise.
- FSM states:
  - IDLE: rx_ready=0, cpu_hold=1. load_req -> LOAD.
  - LOAD: rx_ready=1, cpu_hold=1. Accepts 4*WORDS bytes, big-endian per word (first byte goes to bits [31:24]).
    - A 2-bit lane counter and a 24-bit shift register assemble each word.
    - On the edge that accepts lane 3: mem[load_addr] <= {shift[23:0], rx_data}, and load_addr increments.
    - When that write is word WORDS-1, the next state is CHECK.
  - CHECK: rx_ready=1, cpu_hold=1. Accepts one checksum byte.
    - Pass when the 8-bit sum of all image bytes plus the checksum byte equals 8'h00 (mod 256).
    - Pass -> RUN with load_done=1. Fail -> ERR with load_err=1.
  - RUN: rx_ready=0, cpu_hold=0, load_done=1. load_req -> LOAD.
  - ERR: rx_ready=0, cpu_hold=1, load_err=1. load_req -> LOAD.
- Entering LOAD from any state:
  - clears the lane counter, load_addr, the checksum accumulator, load_done and load_err;
  - sets cpu_hold=1 on the same edge.
- load_req takes priority over a byte accepted in the same cycle. That byte is discarded, and the restart is counted from the next accepted byte.
- Latency:
  - cpu_hold falls on the same edge as the CHECK byte is accepted (state becomes RUN).
  - inst and d_f_rom reflect a written word from the edge after the write.
- Read ports:
  - Combinational and always live, including during a load.
  - Address bits above DEPTH_LOG2+1 and bits [1:0] are ignored.
  - When a and rom_a address the same word, both return the same value.
- load_addr wraps to 0 after the final increment. No write occurs outside LOAD.
- Asynchronous reset mid-load returns the FSM to IDLE with cpu_hold=1. Partially written RAM words keep their new values.

Decomposition:
- Shared package mio_pkg holds:
  - FSM state encoding {IDLE, LOAD, CHECK, RUN, ERR};
  - the MIO word width constant (32);
  - default DEPTH_LOG2.
- One sub-module, mio_dpram: 2**DEPTH_LOG2 x 32 RAM with one synchronous write port and two asynchronous read ports.
- The FSM, word assembly and checksum stay in the top module.

Test Plan:
- Reset: clrn=0 then 1 -> cpu_hold=1, rx_ready=0, load_done=0, load_err=0, load_addr=0; with no load_req, no state change for 100 cycles.
- Full load, WORDS=128:
  - stimulus: load_req pulse, then 512 bytes where word 0 = 20 1D 10 00 and word 0x40 = 08 00 00 40, then the correct checksum;
  - response: a=0 gives inst=32'h201D1000; rom_a=32'h100 gives d_f_rom=32'h08000040; load_done=1; cpu_hold falls on the edge the checksum byte is accepted.
- Bad checksum: same image with checksum+1 -> load_err=1, load_done=0, cpu_hold stays 1, state ERR; a second load_req plus a good image -> RUN.
- Backpressure and gaps: rx_valid toggled at random with idle gaps of 0-5 cycles -> image identical to the gap-free load; no byte is lost or duplicated.
- Restart mid-load: load_req after 37 bytes -> load_addr=0, lane counter cleared; a following full good image passes its checksum.
- Reload from RUN: load_req -> cpu_hold=1 on the next edge; rx_ready=1; load_done clears on the same edge.
